jtcontra_sdram_resp: RTL and testbench
======================================

Name: jtcontra_sdram_resp

Overview:
- Responder end of the SDRAM slot bus that the game top and its ROM slot arbiter drive. The arbiter issues sdram_req and sdram_addr; this block returns sdram_ack, data_rdy and 32-bit data_read.
- Also absorbs byte writes during download (prog_we/prog_addr/prog_data/prog_mask) and schedules refresh, gated by refresh_en.
- Backs onto a generic 16-bit synchronous memory with fixed read latency. Used as the SDRAM stand-in for simulation and for FPGA targets with block/PSRAM storage.

Parameters:
- AW, 22, word address width of sdram_addr/prog_addr/mem_addr.
- CL, 2, mem_dout latency in cycles after mem_rd (1..7).
- REF_PERIOD, 384, cycles between refresh requests.
- REF_LEN, 4, cycles one refresh occupies the memory.

Ports:
- clk  in  1  system clock; all logic single-clock.
- rst  in  1  asynchronous, active-low reset.
- sdram_req  in  1  read request from the slot arbiter.
- sdram_addr  in  AW  16-bit word address of the read.
- sdram_ack  out  1  one-cycle pulse: request/write accepted.
- data_rdy  out  1  one-cycle pulse: data_read valid.
- data_read  out  32  {word A+1, word A}.
- refresh_en  in  1  refresh permitted now.
- downloading  in  1  ROM download in progress.
- prog_we  in  1  byte write strobe.
- prog_addr  in  AW  write word address.
- prog_data  in  8  write byte.
- prog_mask  in  2  active-low byte lane enables.
- mem_addr  out  AW  backing memory address.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_wmask  out  2  active-high byte enables.
- mem_din  out  16  write data.
- mem_dout  in  16  read data, valid CL cycles after mem_rd.
- mem_ref  out  1  high during refresh.

Behaviour:
- Reset (rst low, async): all outputs 0, data_read 0, FSM IDLE, refresh counter 0, ref_pending 0. Reset mid-transaction aborts it; no ack or data_rdy follows.
- FSM states: IDLE, RD0, RD1, RWAIT, DONE, WR, REF.
- IDLE priority, evaluated each cycle:
  - downloading & prog_we -> WR
  - else ref_pending & refresh_en -> REF
  - else sdram_req & !downloading -> RD0
  - else stay in IDLE.
- Read timing (cycle 0 = req sampled in IDLE):
  - Cycle 1 (RD0): sdram_ack=1, mem_rd=1, mem_addr=A.
  - Cycle 2 (RD1): mem_rd=1, mem_addr=A+1 mod 2^AW.
  - Word0 captured at cycle 1+CL into data_read[15:0]; word1 captured at cycle 2+CL into data_read[31:16].
  - Cycle 3+CL (DONE): data_rdy=1, then return to IDLE.
  - data_read holds its value until the next capture. For CL=2, data_rdy is at cycle 5.
- sdram_addr is registered at cycle 0. Later changes do not affect an in-flight read.
- If sdram_req is still high on return to IDLE, a new read starts (the arbiter drops req after ack).
- Requests arriving outside IDLE are not latched; req is level-sampled only in IDLE.
- While downloading=1, read requests get no ack.
- Write (WR, one cycle):
  - mem_wr=1, mem_addr=prog_addr, mem_din={prog_data,prog_data}, mem_wmask=~prog_mask.
  - sdram_ack=1 in the same cycle; back to IDLE.
  - prog_mask=2'b11 still performs the cycle with mem_wmask=0.
- Refresh:
  - Free-running counter wraps at REF_PERIOD-1 and sets ref_pending.
  - ref_pending saturates (one pending max) while refresh_en=0.
  - REF state holds mem_ref=1 for REF_LEN cycles, clears ref_pending, then returns to IDLE.
- mem_rd, mem_wr, sdram_ack and data_rdy are never high together, except that sdram_ack coincides with mem_rd in RD0 and with mem_wr in WR.

Optional Feature:
- Macro: JTCONTRA_SDRAM_STATS_EN.
- Defined: adds outputs rd_cnt[15:0] (increments on each data_rdy) and ref_cnt[15:0] (increments on each REF entry). Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- CL=2, mem[0x100]=16'h1234, mem[0x101]=16'hABCD. Pulse req, addr 0x100 -> ack at cycle 1, data_rdy at cycle 5, data_read=32'hABCD1234.
- downloading=1, prog_we with addr 0x10, data 8'h5A, mask 2'b10 -> mem_wr 1 cycle, mem_wmask=2'b01, mem_din=16'h5A5A, ack same cycle. Req asserted meanwhile -> no ack.
- Read of addr 22'h3FFFFF -> second mem_rd at addr 0; data_read = {mem[0], mem[3FFFFF]}.
- refresh_en=0 for 3*REF_PERIOD, then 1 -> exactly one REF of REF_LEN cycles. With req pending at the same cycle -> REF first, read ack at REF end+1.
- rst low at cycle 3 of a read -> outputs 0 immediately, no data_rdy afterwards. Read after release -> normal latency.
- STATS_EN: 3 reads + 2 refreshes -> rd_cnt=3, ref_cnt=2.

Source files
------------

// File: rtl/jtcontra_sdram_resp.sv
// SDRAM slot-bus responder backed by a generic 16-bit synchronous memory.
// It serves 32-bit reads as two consecutive 16-bit word reads, absorbs byte
// writes during ROM download and schedules periodic refresh cycles.
// Optional build macro: JTCONTRA_SDRAM_STATS_EN adds the rd_cnt/ref_cnt
// saturating activity counters.
module jtcontra_sdram_resp #(
    parameter int AW         = 22,
    parameter int CL         = 2,
    parameter int REF_PERIOD = 384,
    parameter int REF_LEN    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sdram_req,
    input  logic [AW-1:0] sdram_addr,
    output logic          sdram_ack,
    output logic          data_rdy,
    output logic [31:0]   data_read,
    input  logic          refresh_en,
    input  logic          downloading,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [1:0]    prog_mask,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [1:0]    mem_wmask,
    output logic [15:0]   mem_din,
    input  logic [15:0]   mem_dout,
    output logic          mem_ref
`ifdef JTCONTRA_SDRAM_STATS_EN
    ,
    output logic [15:0]   rd_cnt,
    output logic [15:0]   ref_cnt
`endif
);

    localparam int RCW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int LCW = $clog2(REF_LEN + 1);

    typedef enum logic [2:0] {IDLE, RD0, RD1, RWAIT, DONE, WR, REF} state_t;

    state_t         state;
    logic [3:0]     cyc;          // read cycle number, 1 in RD0
    logic [LCW-1:0] ref_left;     // REF cycles remaining after the current one
    logic [RCW-1:0] ref_timer;
    logic           ref_pending;
    logic           start_wr;
    logic           start_ref;
    logic           start_rd;

    // IDLE arbitration: download writes first, then refresh, then reads
    always_comb begin
        start_wr  = 1'b0;
        start_ref = 1'b0;
        start_rd  = 1'b0;
        if (state == IDLE) begin
            if (downloading && prog_we)
                start_wr = 1'b1;
            else if (ref_pending && refresh_en)
                start_ref = 1'b1;
            else if (sdram_req && !downloading)
                start_rd = 1'b1;
        end
    end

    // Free-running refresh timer; one pending refresh is remembered at most
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_timer   <= '0;
            ref_pending <= 1'b0;
        end else begin
            if (ref_timer == RCW'(REF_PERIOD - 1)) begin
                ref_timer   <= '0;
                ref_pending <= 1'b1;
            end else begin
                ref_timer <= ref_timer + 1'b1;
                if (start_ref)
                    ref_pending <= 1'b0;
            end
        end
    end

    // Main FSM; every memory/bus strobe is registered on the state transition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cyc       <= '0;
            ref_left  <= '0;
            sdram_ack <= 1'b0;
            data_rdy  <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wmask <= 2'b00;
            mem_din   <= '0;
            mem_ref   <= 1'b0;
        end else begin
            sdram_ack <= 1'b0;
            data_rdy  <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wmask <= 2'b00;
            case (state)
                IDLE: begin
                    if (start_wr) begin
                        state     <= WR;
                        sdram_ack <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= prog_addr;
                        mem_din   <= {prog_data, prog_data};
                        mem_wmask <= ~prog_mask;
                    end else if (start_ref) begin
                        state    <= REF;
                        mem_ref  <= 1'b1;
                        ref_left <= LCW'(REF_LEN - 1);
                    end else if (start_rd) begin
                        state     <= RD0;
                        sdram_ack <= 1'b1;
                        mem_rd    <= 1'b1;
                        mem_addr  <= sdram_addr;
                        cyc       <= 4'd1;
                    end
                end
                RD0: begin
                    state    <= RD1;
                    mem_rd   <= 1'b1;
                    mem_addr <= mem_addr + 1'b1;   // wraps at 2^AW
                    cyc      <= cyc + 1'b1;
                end
                RD1: begin
                    state <= RWAIT;
                    cyc   <= cyc + 1'b1;
                end
                RWAIT: begin
                    if (cyc == 4'(CL + 2)) begin
                        state    <= DONE;
                        data_rdy <= 1'b1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                WR:   state <= IDLE;
                REF: begin
                    if (ref_left == '0) begin
                        mem_ref <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        ref_left <= ref_left - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the two returned words when they reach the end of the read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_read <= '0;
        end else begin
            if ((state == RD1 || state == RWAIT) && cyc == 4'(CL + 1))
                data_read[15:0] <= mem_dout;
            if (state == RWAIT && cyc == 4'(CL + 2))
                data_read[31:16] <= mem_dout;
        end
    end

`ifdef JTCONTRA_SDRAM_STATS_EN
    // Saturating counters of completed reads and refresh entries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt  <= '0;
            ref_cnt <= '0;
        end else begin
            if (data_rdy && rd_cnt != 16'hFFFF)
                rd_cnt <= rd_cnt + 1'b1;
            if (start_ref && ref_cnt != 16'hFFFF)
                ref_cnt <= ref_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_jtcontra_sdram_resp.sv
// Self-checking bench for jtcontra_sdram_resp: plays the backing memory with a
// CL-deep read pipeline and checks bus timing/data against a word-level model.
module tb_jtcontra_sdram_resp;

    localparam int AW         = 22;
    localparam int CL         = 2;
    localparam int REF_PERIOD = 384;
    localparam int REF_LEN    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_ack;
    logic          data_rdy;
    logic [31:0]   data_read;
    logic          refresh_en;
    logic          downloading;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [1:0]    prog_mask;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [1:0]    mem_wmask;
    logic [15:0]   mem_din;
    logic [15:0]   mem_dout;
    logic          mem_ref;
`ifdef JTCONTRA_SDRAM_STATS_EN
    logic [15:0]   rd_cnt;
    logic [15:0]   ref_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int exp_rd_cnt  = 0;
    int exp_ref_cnt = 0;
    int ref_rises   = 0;
    logic mem_ref_d = 1'b0;

    // backing store driven by DUT writes, and the independent expected store
    logic [15:0] mem     [logic [AW-1:0]];
    logic [15:0] exp_mem [logic [AW-1:0]];
    logic [15:0] pipe    [CL];

    jtcontra_sdram_resp #(
        .AW(AW), .CL(CL), .REF_PERIOD(REF_PERIOD), .REF_LEN(REF_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
        .refresh_en(refresh_en), .downloading(downloading),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_mask(prog_mask),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wmask(mem_wmask), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_ref(mem_ref)
`ifdef JTCONTRA_SDRAM_STATS_EN
        , .rd_cnt(rd_cnt), .ref_cnt(ref_cnt)
`endif
    );

    always #5 clk = ~clk;

    // power-up contents of any word never written
    function automatic logic [15:0] init_word(input logic [AW-1:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'h0000_9E37;
        return p[15:0] ^ p[31:16] ^ 16'h5C3A;
    endfunction

    function automatic logic [15:0] rd_mem(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [15:0] exp_word(input logic [AW-1:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
    endfunction

    // memory model: byte-masked writes, read data valid exactly CL cycles later
    always @(posedge clk) begin
        logic [15:0] w;
        if (mem_wr) begin
            w = rd_mem(mem_addr);
            if (mem_wmask[0]) w[7:0]  = mem_din[7:0];
            if (mem_wmask[1]) w[15:8] = mem_din[15:8];
            mem[mem_addr] = w;
        end
        pipe[0] <= mem_rd ? rd_mem(mem_addr) : 16'($urandom);
        for (int k = 1; k < CL; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_dout = pipe[CL-1];

    // count refresh entries
    always @(posedge clk) begin
        if (mem_ref && !mem_ref_d) ref_rises++;
        mem_ref_d <= mem_ref;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {sdram_ack, data_rdy, mem_rd, mem_wr, mem_wmask, mem_ref}, 32'd0);
    endtask

    // wait (bounded) for data_rdy, return cycles waited
    task automatic wait_rdy(input string tag, input logic [31:0] exp_d, output int waited);
        waited = 0;
        while (!data_rdy && waited < 30) begin
            tick();
            waited++;
        end
        check({tag, "_seen"}, {31'd0, data_rdy}, 32'd1);
        check({tag, "_data"}, data_read, exp_d);
        exp_rd_cnt++;
        tick();
        check({tag, "_pulse"}, {31'd0, data_rdy}, 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        logic [AW-1:0] a1;
        logic [31:0]   exp_d;
        int            w;
        a1    = a + 1'b1;
        exp_d = {exp_word(a1), exp_word(a)};
        sdram_req  = 1'b1;
        sdram_addr = a;
        tick();                                   // cycle 1
        check("rd_ack", {31'd0, sdram_ack}, 32'd1);
        check("rd_strobe0", {31'd0, mem_rd}, 32'd1);
        check("rd_addr0", 32'(mem_addr), 32'(a));
        sdram_req  = 1'b0;
        sdram_addr = AW'($urandom);
        tick();                                   // cycle 2
        check("rd_strobe1", {sdram_ack, mem_rd}, 32'd1);
        check("rd_addr1", 32'(mem_addr), 32'(a1));
        wait_rdy("rd", exp_d, w);
        check("rd_latency", 32'(w + 2), 32'(CL + 3));
        $display("read  addr=%06h data=%08h latency=%0d", a, data_read, w + 2);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d, input logic [1:0] m);
        logic [15:0] w;
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        prog_mask = m;
        sdram_req = 1'b1;
        tick();
        check("wr_strobe", {sdram_ack, mem_wr, mem_rd}, 32'b110);
        check("wr_addr", 32'(mem_addr), 32'(a));
        check("wr_din", {16'd0, mem_din}, {16'd0, d, d});
        check("wr_wmask", {30'd0, mem_wmask}, {30'd0, !m[1], !m[0]});
        prog_we = 1'b0;
        tick();
        check("wr_after", {sdram_ack, mem_wr}, 32'd0);
        sdram_req = 1'b0;
        w = exp_word(a);
        if (!m[0]) w[7:0]  = d;
        if (!m[1]) w[15:8] = d;
        exp_mem[a] = w;
        $display("write addr=%06h data=%02h mask=%02b", a, d, m);
    endtask

    task automatic do_refresh(input logic [AW-1:0] a);
        int r0, c, run, w;
        logic [31:0] exp_d;
        exp_d      = {exp_word(a + 1'b1), exp_word(a)};
        sdram_req  = 1'b0;
        refresh_en = 1'b0;
        r0 = ref_rises;
        repeat (3 * REF_PERIOD) tick();
        check("ref_held_off", 32'(ref_rises - r0), 32'd0);
        refresh_en = 1'b1;
        sdram_req  = 1'b1;
        sdram_addr = a;
        tick();
        c = 1; run = 0;
        while (!sdram_ack && c < 30) begin
            if (mem_ref) run++;
            tick();
            c++;
        end
        check("ref_len", 32'(run), 32'(REF_LEN));
        check("ref_ack_cycle", 32'(c), 32'(REF_LEN + 2));
        sdram_req  = 1'b0;
        refresh_en = 1'b0;
        exp_ref_cnt++;
        wait_rdy("ref_rd", exp_d, w);
        repeat (4) tick();
        check("ref_once", 32'(ref_rises - r0), 32'd1);
        $display("refresh len=%0d read_ack_cycle=%0d data=%08h", run, c, data_read);
    endtask

    initial begin
        int w, c, seen;
        logic [AW-1:0] a;
        rst = 1'b0; sdram_req = 1'b0; sdram_addr = '0; refresh_en = 1'b0;
        downloading = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_mask = 2'b11;
        for (int k = 0; k < CL; k++) pipe[k] = '0;
        mem[22'h100] = 16'h1234; exp_mem[22'h100] = 16'h1234;
        mem[22'h101] = 16'hABCD; exp_mem[22'h101] = 16'hABCD;

        repeat (3) tick();
        check_quiet("reset_ctrl");
        check("reset_data", data_read, 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;
        tick();
        check_quiet("idle_ctrl");

        // directed read from the test plan
        do_read(22'h100);
        check("rd_0x100", data_read, 32'hABCD_1234);
        // address wrap
        do_read(22'h3F_FFFF);
        check("rd_wrap", data_read, {init_word(22'h0), init_word(22'h3F_FFFF)});
        // random reads
        for (int i = 0; i < 12; i++) do_read(AW'($urandom));

        // download writes, with requests held meanwhile
        downloading = 1'b1;
        tick();
        do_write(22'h10, 8'h5A, 2'b10);
        for (int i = 0; i < 8; i++)
            do_write(AW'(22'h200 + $urandom_range(0, 5)), 8'($urandom), 2'($urandom));
        do_write(22'h203, 8'hC3, 2'b11);
        sdram_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sdram_ack) seen++;
        end
        check("dl_no_ack", 32'(seen), 32'd0);
        sdram_req   = 1'b0;
        downloading = 1'b0;
        tick();
        do_read(22'h10);
        for (int i = 0; i < 6; i++) do_read(AW'(22'h200 + i));

        // req held high: next read starts on return to IDLE
        sdram_req  = 1'b1;
        sdram_addr = 22'h100;
        tick();
        check("b2b_ack0", {31'd0, sdram_ack}, 32'd1);
        c = 0;
        do begin
            tick();
            c++;
        end while (!sdram_ack && c < 30);
        check("b2b_gap", 32'(c), 32'(CL + 4));
        sdram_req = 1'b0;
        exp_rd_cnt++;                  // first of the pair completed before the second ack
        wait_rdy("b2b", 32'hABCD_1234, w);
        $display("b2b   gap=%0d data=%08h", c, data_read);

        // reset in cycle 3 of a read aborts it
        sdram_req  = 1'b1;
        sdram_addr = 22'h100;
        tick();
        sdram_req = 1'b0;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check_quiet("abort_ctrl");
        check("abort_data", data_read, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        exp_rd_cnt = 0;
        exp_ref_cnt = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (data_rdy || sdram_ack) seen++;
        end
        check("abort_no_rdy", 32'(seen), 32'd0);
        $display("reset abort checked");
        do_read(22'h100);

        // refresh: held off, then served ahead of a simultaneous read
        do_refresh(22'h3F_FFFF);
        a = AW'($urandom);
        do_refresh(a);

`ifdef JTCONTRA_SDRAM_STATS_EN
        check("stats_rd", {16'd0, rd_cnt}, 32'(exp_rd_cnt));
        check("stats_ref", {16'd0, ref_cnt}, 32'(exp_ref_cnt));
        $display("stats rd_cnt=%0d ref_cnt=%0d", rd_cnt, ref_cnt);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
